// File: rtl/mux_rr_arbiter8.sv
// Round-robin owner selection for a shared 8:1 mux datapath.
// Grants are burst-limited and separated by one idle cycle on handover.
module mux_rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       gnt_valid
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam bit LIMITED = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST =
    LIMITED ? 8'(MAX_HOLD - 1) : 8'd0;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic       gv_q, gv_d;

  logic [2:0] win;
  logic [2:0] idx;
  logic       rel;

  // Scan downward so the lowest offset from ptr wins.
  always_comb begin
    win = ptr_q;
    idx = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr_q + 3'(k);
      if (req[idx]) win = idx;
    end
  end

  assign rel = !req[sel_q] ||
               (LIMITED && (cnt_q == HOLD_LAST));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    gv_d    = gv_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          gnt_d   = 8'd1 << win;
          sel_d   = win;
          gv_d    = 1'b1;
          cnt_d   = 8'd0;
        end
      end
      BUSY: begin
        if (rel) begin
          state_d = IDLE;
          gnt_d   = 8'd0;
          gv_d    = 1'b0;
          ptr_d   = sel_q + 3'd1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= 3'd0;
      cnt_q   <= 8'd0;
      gnt_q   <= 8'd0;
      gv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      gv_q    <= gv_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign gnt_valid = gv_q;

endmodule

// File: tb/tb_mux_rr_arbiter8.sv
// Scoreboard bench for mux_rr_arbiter8 at MAX_HOLD = 16, 4 and 0.
// Stimulus queues expected outputs; a negedge monitor checks them.
module tb_mux_rr_arbiter8;

  typedef struct {
    int unsigned tgt;
    int          inst;
    logic [7:0]  g;
    logic [2:0]  s;
    logic        v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_i [3];
  logic [7:0] gnt_o [3];
  logic [2:0] sel_o [3];
  logic       gv_o  [3];
  logic [7:0] prev_g [3];

  int unsigned cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  exp_t q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux_rr_arbiter8 #(.MAX_HOLD(16)) u_h16 (
    .clk(clk), .rst(rst), .req(req_i[0]),
    .gnt(gnt_o[0]), .sel(sel_o[0]), .gnt_valid(gv_o[0])
  );
  mux_rr_arbiter8 #(.MAX_HOLD(4)) u_h4 (
    .clk(clk), .rst(rst), .req(req_i[1]),
    .gnt(gnt_o[1]), .sel(sel_o[1]), .gnt_valid(gv_o[1])
  );
  mux_rr_arbiter8 #(.MAX_HOLD(0)) u_h0 (
    .clk(clk), .rst(rst), .req(req_i[2]),
    .gnt(gnt_o[2]), .sel(sel_o[2]), .gnt_valid(gv_o[2])
  );

  task automatic drive(input logic r, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] c);
    rst      = r;
    req_i[0] = a;
    req_i[1] = b;
    req_i[2] = c;
  endtask

  task automatic exp_push(input int inst, input logic [7:0] g,
                          input logic [2:0] s, input logic v);
    exp_t e;
    e.tgt  = cyc + 1;
    e.inst = inst;
    e.g    = g;
    e.s    = s;
    e.v    = v;
    q.push_back(e);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops plus per-cycle invariants.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].tgt <= cyc) begin
      e = q.pop_front();
      n_vec++;
      if (e.tgt != cyc) begin
        n_bad++;
        $display("FAIL stale inst%0d tgt=%0d cyc=%0d",
                 e.inst, e.tgt, cyc);
      end else if (gnt_o[e.inst] !== e.g ||
                   sel_o[e.inst] !== e.s ||
                   gv_o[e.inst]  !== e.v) begin
        n_bad++;
        $display("FAIL out inst%0d cyc%0d got gnt=%h sel=%0d v=%b want gnt=%h sel=%0d v=%b",
                 e.inst, cyc, gnt_o[e.inst], sel_o[e.inst],
                 gv_o[e.inst], e.g, e.s, e.v);
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (!$onehot0(gnt_o[i]) || (gv_o[i] !== (|gnt_o[i])) ||
          (gv_o[i] && !gnt_o[i][sel_o[i]]) ||
          (prev_g[i] != 8'd0 && gnt_o[i] != 8'd0 &&
           prev_g[i] != gnt_o[i])) begin
        n_bad++;
        $display("FAIL invariant inst%0d cyc%0d got gnt=%h prev=%h sel=%0d v=%b want legal",
                 i, cyc, gnt_o[i], prev_g[i], sel_o[i], gv_o[i]);
      end
      prev_g[i] = gnt_o[i];
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) prev_g[i] = 8'd0;

    // Reset, then idle
    drive(1'b1, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) exp_push(i, 8'h00, 3'd0, 1'b0);
    step();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) exp_push(i, 8'h00, 3'd0, 1'b0);
      step();
    end

    // Dual requesters, pointer wrap
    drive(1'b0, 8'h81, 8'h00, 8'h00);
    exp_push(0, 8'h01, 3'd0, 1'b1); step();
    exp_push(0, 8'h01, 3'd0, 1'b1); step();
    drive(1'b0, 8'h80, 8'h00, 8'h00);
    exp_push(0, 8'h00, 3'd0, 1'b0); step();
    exp_push(0, 8'h80, 3'd7, 1'b1); step();
    exp_push(0, 8'h80, 3'd7, 1'b1); step();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    exp_push(0, 8'h00, 3'd7, 1'b0); step();
    drive(1'b0, 8'h81, 8'h00, 8'h00);
    exp_push(0, 8'h01, 3'd0, 1'b1); step();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    exp_push(0, 8'h00, 3'd0, 1'b0); step();

    // Burst limit 4, two requesters alternate
    drive(1'b0, 8'h00, 8'h0C, 8'h00);
    for (int k = 0; k < 20; k++) begin
      case (k % 10)
        0, 1, 2, 3: exp_push(1, 8'h04, 3'd2, 1'b1);
        4:          exp_push(1, 8'h00, 3'd2, 1'b0);
        9:          exp_push(1, 8'h00, 3'd3, 1'b0);
        default:    exp_push(1, 8'h08, 3'd3, 1'b1);
      endcase
      step();
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    exp_push(1, 8'h00, 3'd3, 1'b0); step();

    // Lone requester re-granted after one idle cycle
    drive(1'b0, 8'h00, 8'h20, 8'h00);
    for (int k = 0; k < 10; k++) begin
      if (k % 5 < 4) exp_push(1, 8'h20, 3'd5, 1'b1);
      else           exp_push(1, 8'h00, 3'd5, 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    exp_push(1, 8'h00, 3'd5, 1'b0); step();

    // Reset mid-grant clears pointer
    drive(1'b0, 8'h10, 8'h00, 8'h00);
    exp_push(0, 8'h10, 3'd4, 1'b1); step();
    exp_push(0, 8'h10, 3'd4, 1'b1); step();
    drive(1'b1, 8'h10, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) exp_push(i, 8'h00, 3'd0, 1'b0);
    step();
    drive(1'b0, 8'h11, 8'h00, 8'h00);
    exp_push(0, 8'h01, 3'd0, 1'b1); step();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    exp_push(0, 8'h00, 3'd0, 1'b0); step();

    // Unlimited hold past counter saturation
    drive(1'b0, 8'h00, 8'h00, 8'h03);
    for (int k = 0; k < 300; k++) begin
      exp_push(2, 8'h01, 3'd0, 1'b1);
      step();
    end
    drive(1'b0, 8'h00, 8'h00, 8'h02);
    exp_push(2, 8'h00, 3'd0, 1'b0); step();
    exp_push(2, 8'h02, 3'd1, 1'b1); step();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    exp_push(2, 8'h00, 3'd1, 1'b0); step();

    @(negedge clk);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL unchecked inst%0d tgt=%0d got none want gnt=%h",
               e.inst, e.tgt, e.g);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter8.md
Name: mux_rr_arbiter8

Overview:
- Round-robin arbiter that shares one 8-to-1 mux datapath among 8 requesters.
- Each cycle it decides which requester owns the mux.
- It drives a one-hot grant vector and the 3-bit select code for the mux's S2..S0 inputs.
- Ownership is held while the owner keeps requesting, up to a bounded burst length.
- Every handover inserts one idle cycle, so mux select changes never coincide with an active grant.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles per ownership. 0 = unlimited (owner holds until it drops req). Legal range 0..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- req  input  8  request vector; req[i]=1 means requester i wants the mux
- gnt  output 8  registered one-hot grant; all-zero when idle
- sel  output 3  registered binary index of the current or last owner; drives S2,S1,S0 (S2 = MSB)
- gnt_valid  output 1  registered; equals OR of gnt

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values (at the first rising edge with rst=1):
  - gnt=8'h00, sel=3'd0, gnt_valid=0.
  - State IDLE, priority pointer ptr=3'd0, hold counter cnt=0.
  - rst overrides every other input, including mid-grant. There is no completion of an in-flight grant.
- State IDLE:
  - gnt=0, gnt_valid=0, sel holds its last value so the mux output stays stable.
  - If req != 0 at a rising edge: pick winner w = first i with req[i]=1, scanning ptr, ptr+1, ... mod 8.
  - At that edge: gnt <= one-hot(w), sel <= w, gnt_valid <= 1, cnt <= 0, state <= BUSY.
  - Grant latency is 1 cycle from the sampled request.
  - If req == 0: stay in IDLE. ptr is unchanged.
- State BUSY (owner = sel):
  - Release occurs at an edge when req[owner]==0, or when MAX_HOLD != 0 and cnt == MAX_HOLD-1.
  - On release: gnt <= 0, gnt_valid <= 0, ptr <= owner+1 mod 8 (7 wraps to 0), state <= IDLE. sel is unchanged.
  - Otherwise: cnt <= cnt+1 (saturating at 255 when MAX_HOLD=0), and grant outputs are held.
- Hold count:
  - A burst-limited owner sees gnt high for exactly MAX_HOLD cycles.
  - A requester dropping req sees gnt fall at the end of the first cycle in which its req is low. That is one cycle of gnt with req low, which is permitted.
- Handover gap: exactly one IDLE cycle (gnt=0) between any two grants, including a re-grant to the same requester.
- Fairness:
  - Because ptr advances past the released owner, a preempted owner is re-granted immediately only if no other req bit is set in the IDLE cycle.
  - Any continuously requesting requester waits at most 7 × (MAX_HOLD+1) cycles when MAX_HOLD != 0.
- Simultaneous events:
  - Requests rising or falling while BUSY do not affect the current grant. Only req[owner] is examined.
  - Arbitration uses req as sampled in the IDLE cycle only.
- Invariants, checked every cycle:
  - gnt is one-hot or zero.
  - gnt_valid == |gnt.
  - When gnt_valid=1, gnt[sel]==1.
  - gnt never changes from one non-zero value directly to another non-zero value.
- Width rules:
  - ptr and sel are 3-bit with natural mod-8 wrap.
  - cnt is 8-bit. Compare against MAX_HOLD-1 only when MAX_HOLD != 0.

Test Plan:
1. Reset, then req=8'h00 for 5 cycles → gnt=8'h00, sel=0, gnt_valid=0 throughout.
2. Dual requesters (MAX_HOLD=16):
   - After reset, req=8'h81 → next cycle gnt=8'h01, sel=0.
   - Clear req[0] → gnt=0 for 1 cycle, then gnt=8'h80, sel=7.
   - Clear req[7] → gnt=0, ptr wraps to 0.
   - Then req=8'h81 → gnt=8'h01 first.
3. Burst limit (MAX_HOLD=4), req=8'h0C held constant → repeating pattern: gnt=8'h04 (sel=2) for 4 cycles, 1 idle cycle, gnt=8'h08 (sel=3) for 4 cycles, 1 idle cycle.
4. Lone requester (MAX_HOLD=4), req=8'h20 held constant → 4 cycles gnt=8'h20 (sel=5), 1 idle cycle, re-granted 8'h20; this repeats.
5. Reset mid-grant: rst=1 for one edge while gnt=8'h10 → next cycle gnt=0, sel=0, gnt_valid=0. Then req=8'h11 → gnt=8'h01 (ptr reset to 0).
6. Unlimited hold (MAX_HOLD=0), req=8'h03 held for 300 cycles → gnt=8'h01 for all 300 cycles with no preemption. Drop req[0] → 1 idle cycle, then gnt=8'h02.
